demux_1to2_stream: RTL and testbench

Registered 1:2 stream demultiplexer: the inverse of the 2:1 input mux. One valid/ready input stream is steered to one of two valid/ready outputs. `sel` is sampled on the first beat of each packet and held until that packet's last beat, so packets are never split across outputs. Each output has a one-entry register slice. The block sits between a shared producer and two independent consumers.

---
 rtl/demux_1to2_stream.sv | 116 +++++++++++
 tb/tb_demux_1to2_stream.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_1to2_stream.sv
// Registered 1:2 valid/ready stream demultiplexer with packet locking.
// Each output has a one-entry register slice and a per-route packet counter.
module demux_1to2_stream #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    input  logic              din_last,
    output logic              din_ready,
    input  logic              sel,
    output logic [DATA_W-1:0] dout_0,
    output logic              dout_0_valid,
    output logic              dout_0_last,
    input  logic              dout_0_ready,
    output logic [DATA_W-1:0] dout_1,
    output logic              dout_1_valid,
    output logic              dout_1_last,
    input  logic              dout_1_ready,
    output logic              busy,
    output logic [7:0]        pkt_cnt_0,
    output logic [7:0]        pkt_cnt_1
);

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t            state;
    logic              route;
    logic [DATA_W-1:0] data_q  [2];
    logic [1:0]        valid_q;
    logic [1:0]        last_q;
    logic [7:0]        cnt_q   [2];

    logic [1:0] out_ready;
    logic       act_route;
    logic       accept;

    assign out_ready = {dout_1_ready, dout_0_ready};

    // sel only matters at the first beat; once locked it may toggle or be X.
    assign act_route = (state == IDLE) ? sel : route;

    // Ready depends only on the active slice, never on din_valid.
    assign din_ready = ~valid_q[act_route] | out_ready[act_route];
    assign accept    = din_valid & din_ready;

    // Packet-boundary FSM; busy is registered alongside the state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            route <= 1'b0;
            busy  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            unique case (state)
                IDLE: begin
                    if (accept && !din_last) begin
                        state <= LOCK;
                        route <= sel;
                        busy  <= 1'b1;
                    end
                end
                LOCK: begin
                    if (accept && din_last) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Output register slices: load on accept, clear valid on drain-only.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 2; i++) begin
                data_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
            valid_q <= '0;
            last_q  <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (accept && (act_route == 1'(i))) begin
                    data_q[i]  <= din;
                    last_q[i]  <= din_last;
                    valid_q[i] <= 1'b1;
                    if (din_last) begin
                        cnt_q[i] <= cnt_q[i] + 8'd1;
                    end
                end else if (valid_q[i] && out_ready[i]) begin
                    valid_q[i] <= 1'b0;
                end
            end
        end
    end

    assign dout_0       = data_q[0];
    assign dout_0_valid = valid_q[0];
    assign dout_0_last  = last_q[0];
    assign dout_1       = data_q[1];
    assign dout_1_valid = valid_q[1];
    assign dout_1_last  = last_q[1];
    assign pkt_cnt_0    = cnt_q[0];
    assign pkt_cnt_1    = cnt_q[1];

endmodule

// File: tb/tb_demux_1to2_stream.sv
// Scoreboard bench for demux_1to2_stream: directed scenarios plus randomized
// packets, with a packet-level reference model and a decoupled output monitor.
module tb_demux_1to2_stream;

    localparam int DATA_W  = 8;
    localparam int TIMEOUT = 500;

    typedef struct {
        logic [DATA_W-1:0] d;
        logic              l;
    } beat_t;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [DATA_W-1:0] din;
    logic              din_valid;
    logic              din_last;
    logic              din_ready;
    logic              sel;
    logic [DATA_W-1:0] dout_0;
    logic              dout_0_valid;
    logic              dout_0_last;
    logic              dout_0_ready;
    logic [DATA_W-1:0] dout_1;
    logic              dout_1_valid;
    logic              dout_1_last;
    logic              dout_1_ready;
    logic              busy;
    logic [7:0]        pkt_cnt_0;
    logic [7:0]        pkt_cnt_1;

    demux_1to2_stream #(.DATA_W(DATA_W)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .din          (din),
        .din_valid    (din_valid),
        .din_last     (din_last),
        .din_ready    (din_ready),
        .sel          (sel),
        .dout_0       (dout_0),
        .dout_0_valid (dout_0_valid),
        .dout_0_last  (dout_0_last),
        .dout_0_ready (dout_0_ready),
        .dout_1       (dout_1),
        .dout_1_valid (dout_1_valid),
        .dout_1_last  (dout_1_last),
        .dout_1_ready (dout_1_ready),
        .busy         (busy),
        .pkt_cnt_0    (pkt_cnt_0),
        .pkt_cnt_1    (pkt_cnt_1)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model state: expected beats per route, packet counts, in-packet flag.
    beat_t      exp_q0[$];
    beat_t      exp_q1[$];
    logic [7:0] m_cnt0 = 8'd0;
    logic [7:0] m_cnt1 = 8'd0;
    logic       m_busy = 1'b0;

    int  cyc     = 0;
    int  busy_hi = 0;
    int  oc0     = 0;
    int  oc1     = 0;
    int  stalls  = 0;
    bit  rand_rdy = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        exp_q0.delete();
        exp_q1.delete();
        m_cnt0 = 8'd0;
        m_cnt1 = 8'd0;
        m_busy = 1'b0;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (reset_n && busy) busy_hi <= busy_hi + 1;

    // Output monitor: a beat leaves a slice at the edge following valid & ready.
    always @(negedge clk) begin
        beat_t e;
        if (reset_n) begin
            if (dout_0_valid && dout_0_ready) begin
                oc0 <= cyc;
                if (exp_q0.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected beat on dout_0: got %0h, expected none", dout_0);
                end else begin
                    e = exp_q0.pop_front();
                    check("dout_0 data", 32'(dout_0), 32'(e.d));
                    check("dout_0 last", 32'(dout_0_last), 32'(e.l));
                end
            end
            if (dout_1_valid && dout_1_ready) begin
                oc1 <= cyc;
                if (exp_q1.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected beat on dout_1: got %0h, expected none", dout_1);
                end else begin
                    e = exp_q1.pop_front();
                    check("dout_1 data", 32'(dout_1), 32'(e.d));
                    check("dout_1 last", 32'(dout_1_last), 32'(e.l));
                end
            end
            check("pkt_cnt_0", 32'(pkt_cnt_0), 32'(m_cnt0));
            check("pkt_cnt_1", 32'(pkt_cnt_1), 32'(m_cnt1));
            check("busy", 32'(busy), 32'(m_busy));
        end
    end

    // Consumer readiness randomizer, active only during the random phase.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) begin
                dout_0_ready = ($urandom_range(0, 3) != 0);
                dout_1_ready = ($urandom_range(0, 3) != 0);
            end
        end
    end

    // Present one beat for packet route r with sel value s; wait for acceptance.
    task automatic send_beat(input logic r, input logic s, input logic [DATA_W-1:0] d,
                             input logic last);
        beat_t b;
        int    waited = 0;
        bit    done   = 0;
        din_valid = 1'b1;
        din       = d;
        din_last  = last;
        sel       = s;
        while (!done) begin
            @(negedge clk);
            if (din_ready) begin
                b.d = d;
                b.l = last;
                if (r) exp_q1.push_back(b);
                else   exp_q0.push_back(b);
                @(posedge clk);
                #1;
                if (last) begin
                    if (r) m_cnt1 = m_cnt1 + 8'd1;
                    else   m_cnt0 = m_cnt0 + 8'd1;
                end
                m_busy = !last;
                done   = 1;
            end else begin
                stalls++;
                waited++;
                @(posedge clk);
                #1;
                if (waited > TIMEOUT) begin
                    tests++;
                    fails++;
                    $display("FAIL din_ready timeout: got 0 for %0d cycles, expected 1", waited);
                    done = 1;
                end
            end
        end
        din_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        din_valid = 1'b0;
        din       = DATA_W'($urandom);
        sel       = 1'($urandom);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic apply_reset();
        reset_n   = 1'b0;
        din_valid = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0;
        int st0;
        int len;
        logic r;

        reset_n      = 1'b0;
        din_valid    = 1'b1;
        din          = 8'hFF;
        din_last     = 1'b0;
        sel          = 1'b0;
        dout_0_ready = 1'b1;
        dout_1_ready = 1'b1;

        // Reset values with din_valid asserted.
        #3;
        check("reset dout_0_valid", 32'(dout_0_valid), 32'd0);
        check("reset dout_1_valid", 32'(dout_1_valid), 32'd0);
        check("reset pkt_cnt_0", 32'(pkt_cnt_0), 32'd0);
        check("reset pkt_cnt_1", 32'(pkt_cnt_1), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset dout_0", 32'(dout_0), 32'd0);
        check("reset dout_1_last", 32'(dout_1_last), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        din_valid = 1'b0;
        reset_n   = 1'b1;
        #1;
        check("din_ready after reset", 32'(din_ready), 32'd1);
        idle(1);

        // Packet locking: sel flips after the first beat, packet stays on route 0.
        b0 = busy_hi;
        send_beat(1'b0, 1'b0, 8'h11, 1'b0);
        send_beat(1'b0, 1'b1, 8'h22, 1'b0);
        send_beat(1'b0, 1'b1, 8'h33, 1'b1);
        idle(3);
        check("lock busy cycles", 32'(busy_hi - b0), 32'd2);
        check("lock pkt_cnt_0", 32'(pkt_cnt_0), 32'd1);
        check("lock pkt_cnt_1", 32'(pkt_cnt_1), 32'd0);

        // Back-to-back route switch without a bubble.
        st0 = stalls;
        send_beat(1'b0, 1'b0, 8'hA5, 1'b1);
        send_beat(1'b1, 1'b1, 8'h5A, 1'b1);
        idle(3);
        check("b2b stalls", 32'(stalls - st0), 32'd0);
        check("b2b consecutive outputs", 32'(oc1 - oc0), 32'd1);

        // Backpressure on route 1.
        dout_1_ready = 1'b0;
        send_beat(1'b1, 1'b1, 8'hB1, 1'b0);
        din_valid = 1'b1;
        din       = 8'hB2;
        din_last  = 1'b1;
        sel       = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("bp din_ready", 32'(din_ready), 32'd0);
            check("bp dout_1_valid", 32'(dout_1_valid), 32'd1);
            check("bp dout_1 held", 32'(dout_1), 32'hB1);
        end
        @(posedge clk);
        #1;
        dout_1_ready = 1'b1;
        send_beat(1'b1, 1'b0, 8'hB2, 1'b1);
        @(negedge clk);
        check("bp second beat valid", 32'(dout_1_valid), 32'd1);
        check("bp second beat data", 32'(dout_1), 32'hB2);
        check("bp second beat last", 32'(dout_1_last), 32'd1);
        @(posedge clk);
        #1;
        idle(2);

        // Counter wrap on route 0.
        apply_reset();
        for (int i = 0; i < 256; i++) begin
            send_beat(1'b0, 1'b0, DATA_W'($urandom), 1'b1);
        end
        idle(1);
        check("wrap pkt_cnt_0", 32'(pkt_cnt_0), 32'd0);
        check("wrap pkt_cnt_1", 32'(pkt_cnt_1), 32'd0);
        send_beat(1'b0, 1'b0, 8'h77, 1'b1);
        idle(1);
        check("wrap 257th pkt_cnt_0", 32'(pkt_cnt_0), 32'd1);

        // Reset in the middle of a packet to route 1.
        send_beat(1'b1, 1'b1, 8'hC1, 1'b0);
        check("mid pre-reset dout_1_valid", 32'(dout_1_valid), 32'd1);
        reset_n   = 1'b0;
        model_clear();
        #1;
        check("mid reset dout_1_valid", 32'(dout_1_valid), 32'd0);
        check("mid reset busy", 32'(busy), 32'd0);
        check("mid reset pkt_cnt_0", 32'(pkt_cnt_0), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        send_beat(1'b0, 1'b0, 8'hD0, 1'b1);
        idle(2);
        check("mid post pkt_cnt_0", 32'(pkt_cnt_0), 32'd1);
        check("mid post pkt_cnt_1", 32'(pkt_cnt_1), 32'd0);

        // Randomized packets with random consumer backpressure and gaps.
        rand_rdy = 1'b1;
        for (int p = 0; p < 150; p++) begin
            len = $urandom_range(1, 4);
            r   = 1'($urandom_range(0, 1));
            for (int b = 0; b < len; b++) begin
                send_beat(r, (b == 0) ? r : 1'($urandom), DATA_W'($urandom), (b == len - 1));
            end
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        rand_rdy = 1'b0;
        @(posedge clk);
        #2;
        dout_0_ready = 1'b1;
        dout_1_ready = 1'b1;
        for (int i = 0; i < 20 && (exp_q0.size() + exp_q1.size()) != 0; i++) begin
            @(posedge clk);
            #1;
        end
        idle(2);
        check("drain route 0 empty", 32'(exp_q0.size()), 32'd0);
        check("drain route 1 empty", 32'(exp_q1.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
